// File: rtl/bratcr_ctrl.sv
// Branch RAT checkpoint store controller: in-order checkpoint allocation, retire-time
// freeing, and mispredict truncation followed by a grouped FRAT restore sequence.
module bratcr_ctrl #(
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int BRATCR_NUM_ETY  = 4,
  parameter int ROB_SIZE_CLOG   = 5,
  parameter int RAT_SIZE        = 32,
  parameter int RESTORE_PER_CYC = 8,
  localparam int EW   = $clog2(BRATCR_NUM_ETY),
  localparam int NGRP = RAT_SIZE / RESTORE_PER_CYC,
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]               alloc_req,
  input  logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0] alloc_robid,
  output logic [ISSUE_WIDTH_MAX-1:0]               alloc_gnt,
  output logic [ISSUE_WIDTH_MAX*EW-1:0]            alloc_ety,
  output logic                                     stall_id,
  input  logic                                     mispredict_val,
  input  logic [ROB_SIZE_CLOG-1:0]                 mispredict_robid,
  input  logic                                     ret_branch_val,
  input  logic [ROB_SIZE_CLOG-1:0]                 ret_branch_robid,
  output logic                                     restore_val,
  output logic [EW-1:0]                            restore_ety,
  output logic [GW-1:0]                            restore_grp,
  output logic                                     restore_done,
  output logic                                     recover_busy,
  output logic                                     err_sticky
);

  localparam int CW = EW + 1;
  localparam logic [CW:0]   CAP      = BRATCR_NUM_ETY[CW:0];
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);
  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_RESTORE = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [EW-1:0]             head_q, head_d;
  logic [EW-1:0]             tail_q, tail_d;
  logic [EW-1:0]             rety_q, rety_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [GW-1:0]             grp_q, grp_d;
  logic [BRATCR_NUM_ETY-1:0] vld_q, vld_d;
  logic                      err_q, err_d;
  logic [ROB_SIZE_CLOG-1:0]  robid_q [BRATCR_NUM_ETY];

  logic [CW-1:0]               n_req;
  logic [CW:0]                 cnt_sum;
  logic                        alloc_ok;
  logic [ISSUE_WIDTH_MAX*EW-1:0] ety_c;
  logic                        hit;
  logic [EW-1:0]               hit_ety;
  logic                        ret_ok;
  logic                        mp_take;

  function automatic logic [EW-1:0] age_f(input logic [EW-1:0] x, input logic [EW-1:0] h);
    return x - h;
  endfunction

  // Lanes are numbered oldest-first, so each requester takes the next slot after tail.
  always_comb begin : alloc_logic
    n_req = '0;
    ety_c = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      if (alloc_req[i]) begin
        ety_c[i*EW +: EW] = tail_q + n_req[EW-1:0];
        n_req = n_req + CW'(1);
      end
    end
    cnt_sum  = {1'b0, cnt_q} + {1'b0, n_req};
    alloc_ok = (state_q == ST_IDLE) && !mispredict_val && (cnt_sum <= CAP);
  end

  always_comb begin : cam_logic
    hit     = 1'b0;
    hit_ety = '0;
    for (int j = 0; j < BRATCR_NUM_ETY; j++) begin
      if (!hit && vld_q[j] && (robid_q[j] == mispredict_robid)) begin
        hit     = 1'b1;
        hit_ety = EW'(j);
      end
    end
    ret_ok  = ret_branch_val && vld_q[head_q] && (robid_q[head_q] == ret_branch_robid);
    // A restart only makes sense for a checkpoint strictly older than the one being restored.
    mp_take = mispredict_val && hit &&
              ((state_q == ST_IDLE) || (age_f(hit_ety, head_q) < age_f(rety_q, head_q)));
  end

  always_comb begin : next_state
    state_d = state_q;
    grp_d   = grp_q;
    rety_d  = rety_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    err_d   = err_q;
    if (alloc_ok) begin
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
        if (alloc_req[i]) vld_d[ety_c[i*EW +: EW]] = 1'b1;
      end
      tail_d = tail_q + n_req[EW-1:0];
      cnt_d  = cnt_q + n_req;
    end
    if (mp_take) begin
      for (int j = 0; j < BRATCR_NUM_ETY; j++) begin
        if (age_f(EW'(j), head_q) > age_f(hit_ety, head_q)) vld_d[j] = 1'b0;
      end
      tail_d  = hit_ety + EW'(1);
      cnt_d   = CW'(age_f(hit_ety, head_q)) + CW'(1);
      state_d = ST_RESTORE;
      grp_d   = '0;
      rety_d  = hit_ety;
    end else if (state_q == ST_RESTORE) begin
      if (grp_q == GRP_LAST) begin
        state_d = ST_IDLE;
        grp_d   = '0;
      end else begin
        grp_d = grp_q + GW'(1);
      end
    end
    if (ret_ok) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + EW'(1);
      cnt_d         = cnt_d - CW'(1);
    end
    if ((mispredict_val && !hit) || (ret_branch_val && !ret_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      rety_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      rety_q  <= rety_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // ROB ids are payload guarded by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
        if (alloc_req[i]) robid_q[ety_c[i*EW +: EW]] <= alloc_robid[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
      end
    end
  end

  assign alloc_gnt    = alloc_ok ? alloc_req : '0;
  assign alloc_ety    = alloc_ok ? ety_c : '0;
  assign stall_id     = (state_q == ST_RESTORE) || ((|alloc_req) && !alloc_ok);
  assign restore_val  = (state_q == ST_RESTORE);
  assign recover_busy = (state_q == ST_RESTORE);
  assign restore_ety  = rety_q;
  assign restore_grp  = grp_q;
  assign restore_done = (state_q == ST_RESTORE) && (grp_q == GRP_LAST);
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_bratcr_ctrl.sv
// Randomized plus directed bench for bratcr_ctrl against a queue-based checkpoint model.
module tb_bratcr_ctrl;
  localparam int IW = 2;
  localparam int NE = 4;
  localparam int RW = 5;
  localparam int NG = 32 / 8;
  localparam int EW = 2;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [IW-1:0]    alloc_req = '0;
  logic [IW*RW-1:0] alloc_robid = '0;
  logic [IW-1:0]    alloc_gnt;
  logic [IW*EW-1:0] alloc_ety;
  logic             stall_id;
  logic             mispredict_val = 1'b0;
  logic [RW-1:0]    mispredict_robid = '0;
  logic             ret_branch_val = 1'b0;
  logic [RW-1:0]    ret_branch_robid = '0;
  logic             restore_val;
  logic [EW-1:0]    restore_ety;
  logic [GW-1:0]    restore_grp;
  logic             restore_done;
  logic             recover_busy;
  logic             err_sticky;

  always #5 clk = ~clk;

  bratcr_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_robid(alloc_robid),
    .alloc_gnt(alloc_gnt), .alloc_ety(alloc_ety), .stall_id(stall_id),
    .mispredict_val(mispredict_val), .mispredict_robid(mispredict_robid),
    .ret_branch_val(ret_branch_val), .ret_branch_robid(ret_branch_robid),
    .restore_val(restore_val), .restore_ety(restore_ety), .restore_grp(restore_grp),
    .restore_done(restore_done), .recover_busy(recover_busy), .err_sticky(err_sticky)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: live checkpoints as a queue of ROB ids, oldest first; q[k] lives in slot (m_head+k)%NE.
  int q[$];
  int m_head;
  bit m_busy;
  int m_grp;
  int m_rety;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_busy = 1'b0;
    m_grp  = 0;
    m_rety = 0;
    m_err  = 1'b0;
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    alloc_req = '0; alloc_robid = '0;
    mispredict_val = 1'b0; mispredict_robid = '0;
    ret_branch_val = 1'b0; ret_branch_robid = '0;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_gnt",   32'(alloc_gnt),    32'd0);
    check_eq("rst_ety",   32'(alloc_ety),    32'd0);
    check_eq("rst_stall", 32'(stall_id),     32'd0);
    check_eq("rst_rval",  32'(restore_val),  32'd0);
    check_eq("rst_rety",  32'(restore_ety),  32'd0);
    check_eq("rst_rgrp",  32'(restore_grp),  32'd0);
    check_eq("rst_done",  32'(restore_done), 32'd0);
    check_eq("rst_busy",  32'(recover_busy), 32'd0);
    check_eq("rst_err",   32'(err_sticky),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic [IW-1:0] req, input int r0, input int r1,
                      input bit mpv, input int mpr, input bit rv, input int rr);
    int n, k, rank;
    bit ok, hit, take, rok;
    logic [IW-1:0]    e_gnt;
    logic [IW*EW-1:0] e_ety;
    int lane_r[IW];
    @(negedge clk);
    alloc_req        = req;
    alloc_robid      = {RW'(r1), RW'(r0)};
    mispredict_val   = mpv;
    mispredict_robid = RW'(mpr);
    ret_branch_val   = rv;
    ret_branch_robid = RW'(rr);
    #1;
    n     = $countones(req);
    ok    = !m_busy && !mpv && (q.size() + n <= NE);
    e_gnt = ok ? req : '0;
    e_ety = '0;
    rank  = 0;
    for (int i = 0; i < IW; i++) begin
      if (ok && req[i]) begin
        e_ety[i*EW +: EW] = EW'((m_head + q.size() + rank) % NE);
        rank++;
      end
    end
    hit = 1'b0;
    k   = 0;
    foreach (q[j]) if (!hit && q[j] == mpr) begin hit = 1'b1; k = j; end
    // While restoring, the restore entry is the youngest live one; only an older hit restarts.
    take = mpv && hit && (!m_busy || k < q.size() - 1);
    rok  = rv && q.size() > 0 && q[0] == rr;
    check_eq("gnt",   32'(alloc_gnt),    32'(e_gnt));
    check_eq("ety",   32'(alloc_ety),    32'(e_ety));
    check_eq("stall", 32'(stall_id),     32'(m_busy || (req != '0 && !ok)));
    check_eq("rval",  32'(restore_val),  32'(m_busy));
    check_eq("rbusy", 32'(recover_busy), 32'(m_busy));
    check_eq("rgrp",  32'(restore_grp),  m_busy ? 32'(m_grp) : 32'd0);
    check_eq("rdone", 32'(restore_done), 32'(m_busy && m_grp == NG - 1));
    if (m_busy) check_eq("rety", 32'(restore_ety), 32'(m_rety));
    check_eq("err",   32'(err_sticky),   32'(m_err));
    @(posedge clk);
    lane_r[0] = r0;
    lane_r[1] = r1;
    if (ok) for (int i = 0; i < IW; i++) if (req[i]) q.push_back(lane_r[i]);
    if (take) begin
      while (q.size() > k + 1) void'(q.pop_back());
      m_busy = 1'b1;
      m_grp  = 0;
      m_rety = (m_head + k) % NE;
    end else if (m_busy) begin
      if (m_grp == NG - 1) begin m_busy = 1'b0; m_grp = 0; end
      else m_grp++;
    end
    if (rok) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % NE;
    end
    if ((mpv && !hit) || (rv && !rok)) m_err = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic int fresh_robid(input int excl);
    int r;
    bit used;
    for (int tries = 0; tries < 64; tries++) begin
      r = int'($urandom_range(0, 31));
      used = (r == excl);
      foreach (q[j]) if (q[j] == r) used = 1'b1;
      if (!used) return r;
    end
    return (excl + 1) % 32;
  endfunction

  initial begin
    int r0, r1, mpr, rr;
    bit mpv, rv;
    logic [IW-1:0] req;
    model_reset();
    async_reset_check();

    // Dual alloc, fill, full stall with same-cycle retire, then grant on wrapped slot.
    step(2'b11, 3, 4, 1'b0, 0, 1'b0, 0);
    step(2'b11, 5, 6, 1'b0, 0, 1'b0, 0);
    step(2'b01, 7, 0, 1'b0, 0, 1'b1, 3);
    step(2'b01, 7, 0, 1'b0, 0, 1'b0, 0);
    idle(1);

    // Mispredict on robid 4, full restore, then older restart and an unmatched mispredict.
    async_reset_check();
    step(2'b11, 3, 4, 1'b0, 0, 1'b0, 0);
    step(2'b11, 5, 6, 1'b0, 0, 1'b0, 0);
    step(2'b00, 0, 0, 1'b1, 4, 1'b0, 0);
    idle(5);
    step(2'b11, 8, 9, 1'b0, 0, 1'b0, 0);
    step(2'b00, 0, 0, 1'b1, 9, 1'b0, 0);
    step(2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step(2'b00, 0, 0, 1'b1, 3, 1'b0, 0);
    step(2'b00, 0, 0, 1'b1, 6, 1'b0, 0);
    idle(5);

    // Mispredict beats same-cycle alloc; retire with non-head robid.
    async_reset_check();
    step(2'b11, 3, 4, 1'b0, 0, 1'b0, 0);
    step(2'b11, 5, 6, 1'b1, 3, 1'b0, 0);
    idle(4);
    step(2'b00, 0, 0, 1'b0, 0, 1'b1, 9);
    idle(1);

    // Single alloc/retire wrap, then async reset two cycles into a restore.
    async_reset_check();
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 10 + i, 0, 1'b0, 0, 1'b0, 0);
      step(2'b00, 0, 0, 1'b0, 0, 1'b1, 10 + i);
    end
    step(2'b11, 1, 2, 1'b0, 0, 1'b0, 0);
    step(2'b00, 0, 0, 1'b1, 2, 1'b0, 0);
    step(2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    async_reset_check();
    idle(2);

    for (int blk = 0; blk < 6; blk++) begin
      async_reset_check();
      for (int c = 0; c < 150; c++) begin
        req = IW'($urandom_range(0, 3));
        r0  = fresh_robid(-1);
        r1  = fresh_robid(r0);
        mpv = ($urandom_range(0, 9) == 0);
        mpr = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
              q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, 31));
        rv  = ($urandom_range(0, 2) == 0);
        rr  = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[0] : int'($urandom_range(0, 31));
        step(req, r0, r1, mpv, mpr, rv, rr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
